// File: rtl/if_stage_ctrl_if.sv
// Bundle of the IF/ID/EX-MEM signals seen by the front-end controller.
interface if_stage_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      IF_PC;
    logic             IF_is_branch;
    logic             ID_load_use;
    logic             EM_branch_valid;
    logic [31:0]      EM_PC;
    logic             EM_PCSrc;
    logic             EM_pred_taken;
    logic [1:0]       EM_jump;
    logic             IFWrite;
    logic             PCWrite;
    logic             IF_Flush;
    logic             branch_taken;
    logic             redirect;
    logic [1:0]       redirect_sel;
    logic [CNT_W-1:0] mispredict_cnt;

    // Controller side: consumes pipeline status, drives the enables and PC select.
    modport master (
        input  IF_PC, IF_is_branch, ID_load_use, EM_branch_valid,
        input  EM_PC, EM_PCSrc, EM_pred_taken, EM_jump,
        output IFWrite, PCWrite, IF_Flush, branch_taken,
        output redirect, redirect_sel, mispredict_cnt
    );

    // Pipeline side: provides status, obeys the controller.
    modport slave (
        output IF_PC, IF_is_branch, ID_load_use, EM_branch_valid,
        output EM_PC, EM_PCSrc, EM_pred_taken, EM_jump,
        input  IFWrite, PCWrite, IF_Flush, branch_taken,
        input  redirect, redirect_sel, mispredict_cnt
    );
endinterface

// File: rtl/if_stage_ctrl.sv
// IF/ID and PC front-end controller: BHT branch prediction, load-use stall
// sequencing and redirect/flush sequencing for mispredicts and jumps.
module if_stage_ctrl #(
    parameter int unsigned BHT_IDX_W    = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,   // synchronous, active-high despite the name
    if_stage_ctrl_if.master bus
);
    localparam int unsigned BHT_N  = 1 << BHT_IDX_W;
    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         bht_q [BHT_N];
    logic [1:0]         bht_d [BHT_N];

    logic                 mispred, jmp;
    logic [BHT_IDX_W-1:0] fetch_idx, em_idx;
    logic                 if_write, pc_write, if_flush, br_taken, redir;
    logic [1:0]           redir_sel;

    // Next-state, BHT/counter update and same-cycle control outputs.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        cnt_d     = cnt_q;
        bht_d     = bht_q;
        if_write  = 1'b1;
        pc_write  = 1'b1;
        if_flush  = 1'b0;
        br_taken  = 1'b0;
        redir     = 1'b0;
        redir_sel = 2'd0;

        mispred   = bus.EM_branch_valid & (bus.EM_PCSrc != bus.EM_pred_taken);
        jmp       = (bus.EM_jump == 2'd1) | (bus.EM_jump == 2'd2);
        fetch_idx = bus.IF_PC[BHT_IDX_W+1:2];
        em_idx    = bus.EM_PC[BHT_IDX_W+1:2];

        if (mispred | jmp) begin
            // Redirect event overrides any stall or flush in progress.
            redir     = 1'b1;
            if_write  = 1'b0;
            if_flush  = 1'b1;
            redir_sel = jmp ? 2'd2 : (bus.EM_PCSrc ? 2'd0 : 2'd1);
            fcnt_d    = FCNT_W'(FLUSH_LOAD);
            state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    br_taken = bus.IF_is_branch & bht_q[fetch_idx][1];
                    if (bus.ID_load_use) begin
                        if_write = 1'b0;
                        pc_write = 1'b0;
                        state_d  = STALL;
                    end else begin
                        state_d  = RUN;
                    end
                end
                FLUSH: begin
                    if_write = 1'b0;
                    if_flush = 1'b1;
                    if (fcnt_q <= FCNT_W'(1)) begin
                        fcnt_d  = '0;
                        state_d = RUN;
                    end else begin
                        fcnt_d  = fcnt_q - FCNT_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // Resolved branches train the BHT regardless of redirect activity.
        if (bus.EM_branch_valid) begin
            if (bus.EM_PCSrc) begin
                if (bht_q[em_idx] != 2'd3) bht_d[em_idx] = bht_q[em_idx] + 2'd1;
            end else begin
                if (bht_q[em_idx] != 2'd0) bht_d[em_idx] = bht_q[em_idx] - 2'd1;
            end
        end

        if (mispred && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

        // Reset holds the pipeline in free-running fetch.
        if (rst_n) begin
            if_write  = 1'b1;
            pc_write  = 1'b1;
            if_flush  = 1'b0;
            br_taken  = 1'b0;
            redir     = 1'b0;
            redir_sel = 2'd0;
        end
    end

    // State, flush counter, mispredict counter and BHT registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= bht_d[i];
        end
    end

    assign bus.IFWrite        = if_write;
    assign bus.PCWrite        = pc_write;
    assign bus.IF_Flush       = if_flush;
    assign bus.branch_taken   = br_taken;
    assign bus.redirect       = redir;
    assign bus.redirect_sel   = redir_sel;
    assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl (CNT_W=4 build to reach saturation quickly).
module tb_if_stage_ctrl;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    if_stage_ctrl_if #(.CNT_W(CW)) bus ();

    if_stage_ctrl #(
        .BHT_IDX_W   (4),
        .FLUSH_CYCLES(2),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are changed at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic em_idle();
        bus.EM_branch_valid = 1'b0;
        bus.EM_PCSrc        = 1'b0;
        bus.EM_pred_taken   = 1'b0;
        bus.EM_jump         = 2'd0;
        bus.EM_PC           = 32'h0;
    endtask

    task automatic em_branch(input logic [31:0] pc, input logic taken, input logic pred);
        bus.EM_branch_valid = 1'b1;
        bus.EM_PC           = pc;
        bus.EM_PCSrc        = taken;
        bus.EM_pred_taken   = pred;
    endtask

    // Control outputs packed {IFWrite, PCWrite, IF_Flush, redirect, redirect_sel}.
    function automatic logic [31:0] ctl();
        return {26'd0, bus.IFWrite, bus.PCWrite, bus.IF_Flush, bus.redirect, bus.redirect_sel};
    endfunction

    localparam logic [31:0] C_RUN   = 32'b1_1_0_0_00 ;
    localparam logic [31:0] C_HOLD  = 32'b0_0_0_0_00 ;
    localparam logic [31:0] C_FLUSH = 32'b0_1_1_0_00 ;
    localparam logic [31:0] C_EV0   = 32'b0_1_1_1_00 ;
    localparam logic [31:0] C_EV1   = 32'b0_1_1_1_01 ;
    localparam logic [31:0] C_EV2   = 32'b0_1_1_1_10 ;

    initial begin
        rst_n            = 1'b1;
        bus.IF_PC        = 32'h40;
        bus.IF_is_branch = 1'b1;
        bus.ID_load_use  = 1'b0;
        em_idle();
        @(negedge clk);
        tick();
        #1 check("rst_ctl", ctl(), C_RUN);
        check("rst_pred", 32'(bus.branch_taken), 0);
        check("rst_cnt", 32'(bus.mispredict_cnt), 0);
        rst_n = 1'b0;

        // Fresh BHT predicts weakly not-taken.
        #1 check("init_ctl", ctl(), C_RUN);
        check("init_pred", 32'(bus.branch_taken), 0);

        // Two taken mispredicts at 0x40, each with a 2-cycle flush.
        for (int e = 0; e < 2; e++) begin
            em_branch(32'h40, 1'b1, 1'b0);
            #1 check("mp_ev_ctl", ctl(), C_EV0);
            check("mp_ev_pred", 32'(bus.branch_taken), 0);
            tick();
            em_idle();
            #1 check("mp_cnt", 32'(bus.mispredict_cnt), 32'(e + 1));
            check("mp_flush_ctl", ctl(), C_FLUSH);
            check("mp_flush_pred", 32'(bus.branch_taken), 0);
            tick();
            #1 check("mp_run_ctl", ctl(), C_RUN);
        end
        check("pred_taken_40", 32'(bus.branch_taken), 1);
        bus.IF_is_branch = 1'b0;
        #1 check("pred_nonbranch", 32'(bus.branch_taken), 0);
        bus.IF_is_branch = 1'b1;

        // Jump code 3 is not a redirect.
        bus.EM_jump = 2'd3;
        #1 check("jump3_ctl", ctl(), C_RUN);
        tick();
        em_idle();

        // Correctly predicted not-taken at 0x80 (same index as 0x40): 11->10->01,
        // fetch sees the pre-update value each cycle.
        em_branch(32'h80, 1'b0, 1'b0);
        #1 check("old_read_11", 32'(bus.branch_taken), 1);
        tick();
        #1 check("old_read_10", 32'(bus.branch_taken), 1);
        check("no_ev_ctl", ctl(), C_RUN);
        tick();
        em_idle();
        #1 check("old_read_01", 32'(bus.branch_taken), 0);
        check("cnt_hold", 32'(bus.mispredict_cnt), 2);

        // Load-use for 3 cycles in RUN.
        bus.ID_load_use = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("lu_hold", ctl(), C_HOLD);
            tick();
        end
        bus.ID_load_use = 1'b0;
        #1 check("lu_release", ctl(), C_RUN);
        tick();
        #1 check("lu_run", ctl(), C_RUN);

        // Jump during stall; stall ignored in FLUSH; second jump reloads the flush.
        bus.ID_load_use = 1'b1;
        tick();
        bus.EM_jump = 2'd2;
        #1 check("stall_jmp_ctl", ctl(), C_EV2);
        tick();
        bus.EM_jump = 2'd0;
        #1 check("flush_ign_lu", ctl(), C_FLUSH);
        bus.EM_jump = 2'd1;
        #1 check("flush_rejmp", ctl(), C_EV2);
        tick();
        bus.EM_jump = 2'd0;
        #1 check("reload_flush", ctl(), C_FLUSH);
        tick();
        #1 check("post_flush_lu", ctl(), C_HOLD);
        bus.ID_load_use = 1'b0;
        tick();
        check("jmp_cnt_same", 32'(bus.mispredict_cnt), 2);

        // Mispredict and jump together at 0x44: jump select wins, count and BHT update.
        em_branch(32'h44, 1'b1, 1'b0);
        bus.EM_jump = 2'd1;
        #1 check("both_ctl", ctl(), C_EV2);
        tick();
        em_idle();
        #1 check("both_cnt", 32'(bus.mispredict_cnt), 3);
        tick();
        bus.IF_PC = 32'h44;
        #1 check("both_bht", 32'(bus.branch_taken), 1);

        // Not-taken mispredict selects the fall-through.
        em_branch(32'h4c, 1'b0, 1'b1);
        #1 check("nt_mp_ctl", ctl(), C_EV1);
        tick();
        em_idle();
        #1 check("nt_mp_cnt", 32'(bus.mispredict_cnt), 4);

        // Back-to-back mispredicts to saturation (4 + 11 = 15).
        for (int k = 0; k < 11; k++) begin
            em_branch(32'h48, 1'b1, 1'b0);
            tick();
        end
        #1 check("sat_reach", 32'(bus.mispredict_cnt), 32'hF);
        tick();
        em_idle();
        #1 check("sat_hold", 32'(bus.mispredict_cnt), 32'hF);
        check("sat_in_flush", ctl(), C_FLUSH);

        // Reset in the middle of FLUSH.
        rst_n = 1'b1;
        #1 check("rst_mid_ctl", ctl(), C_RUN);
        tick();
        rst_n = 1'b0;
        bus.IF_PC = 32'h48;
        #1 check("rst_after_ctl", ctl(), C_RUN);
        check("rst_after_cnt", 32'(bus.mispredict_cnt), 0);
        check("rst_after_bht", 32'(bus.branch_taken), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
